clint_trap_ctrl: RTL and testbench
==================================

# clint_trap_ctrl

Parametrised machine-mode trap controller that replaces the fixed timer-only interrupt unit between the decode stage and the CSR file. It arbitrates synchronous exceptions (illegal instruction, ecall, ebreak), any number of enabled machine interrupt lines, and mret. It writes mepc/mcause/mtval/mstatus in one cycle and then issues a fetch redirect with a valid/ready handshake. Direct and vectored mtvec modes are both supported.

## Interface

- XLEN, 64, data/address width
- IRQ_W, 16, width of interrupt pending/enable vectors; bit i has interrupt cause code i; must be ≥ 12

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid_i  in  1  decode holds a valid instruction; events are considered only when high
- pc_i  in  XLEN  pc of the decode instruction
- jump_i  in  1  a redirect from the older instruction is in flight
- jump_pc_i  in  XLEN  target of that redirect
- inst_i  in  32  instruction bits, used for mtval
- expt_info_i  in  4  {illegal, ecall, ebreak, mret}
- irq_pend_i  in  IRQ_W  raw interrupt pending lines (mip)
- csr_mie_i  in  IRQ_W  interrupt enables (mie)
- csr_mstatus_i, csr_mtvec_i, csr_mepc_i  in  XLEN  current CSR values
- mepc_wen_o / mepc_wdata_o  out  1 / XLEN  mepc write
- mcause_wen_o / mcause_wdata_o  out  1 / XLEN  mcause write
- mtval_wen_o / mtval_wdata_o  out  1 / XLEN  mtval write
- mstatus_wen_o / mstatus_wdata_o  out  1 / XLEN  mstatus write
- redirect_valid_o  out  1  fetch redirect request
- redirect_addr_o  out  XLEN  redirect target
- redirect_ready_i  in  1  fetch accepts the redirect
- hold_o  out  1  stall request to the pipeline (combinational)

## Operation

- States: IDLE, TRAP, MRET, REDIR.
- Event detection happens only in IDLE with inst_valid_i=1. Priority: illegal > ecall > ebreak > interrupt > mret.
- Interrupt taken when mstatus[3] (MIE)=1 and (irq_pend_i & csr_mie_i)≠0.
  - Selection order: bit 11, then bit 3, then bit 7, then the remaining set bits from the highest index down.
- mcause values:
  - illegal = 2, ebreak = 3, ecall = 11.
  - Interrupt = {1'b1, zero-extended index i}.
- mepc:
  - Interrupt: jump_pc_i if jump_i=1, else pc_i.
  - Exception: pc_i.
- mtval: zero-extended inst_i for illegal; 0 for all other traps.
- Trap mstatus write: MPIE(7) ← MIE(3), MIE ← 0, MPP(12:11) ← 2'b11; all other bits pass through.
- Mret mstatus write: MIE ← MPIE, MPIE ← 1, MPP ← 2'b11; other bits pass through.
- Redirect address:
  - Interrupt with csr_mtvec_i[1:0]=2'b01: {mtvec[XLEN-1:2],2'b00} + 4·i.
  - All other traps, and mtvec modes 0/2/3: {mtvec[XLEN-1:2],2'b00}.
  - Mret: csr_mepc_i, sampled in the MRET state.
- Transitions:
  - IDLE → TRAP on an exception or interrupt; IDLE → MRET on mret.
  - TRAP → REDIR and MRET → REDIR unconditionally.
  - REDIR → IDLE on redirect_valid_o & redirect_ready_i.
- Events are ignored outside IDLE.
- hold_o = (IDLE & event detected) | (state ≠ IDLE).

## Timing

- Async reset: state goes to IDLE immediately. Every registered output (all wen, wdata, redirect_valid_o, redirect_addr_o) goes to 0. A reset mid-trap abandons the sequence with no partial writes afterward.
- Event seen in cycle N:
  - Edge ending N loads state, wdata and wen registers.
  - Cycle N+1 (TRAP/MRET): the relevant wen signals are high for exactly one cycle.
    - TRAP asserts mepc, mcause, mtval and mstatus.
    - MRET asserts mstatus only.
  - Cycle N+2: redirect_valid_o=1 with a stable redirect_addr_o. It stays asserted until ready is sampled high at a clock edge, then drops on the next cycle.
- Minimum trap-to-idle time is 3 cycles, reached when ready is high during N+2.
- wdata registers hold their last value when wen=0.
- A simultaneous exception and interrupt takes the exception; the interrupt stays pending for later.
- Interrupt deassertion after cycle N does not cancel the sequence.

## Test plan

- Reset with all inputs X→0: every output 0 and hold_o=0; release reset, idle for 10 cycles, no wen pulses.
- ecall at pc=0x8000_0100, mtvec=0x8000_0000, mstatus=0x8:
  - N+1: mepc=0x8000_0100, mcause=11, mtval=0, mstatus=0x1880 with all four wen high for one cycle.
  - N+2: redirect to 0x8000_0000.
- Vectored interrupt: irq_pend=mie=0x0880, MIE=1, mtvec=0x8000_0001, jump_i=1, jump_pc=0x8000_0200:
  - Bit 11 wins; mcause=0x8000_0000_0000_000B, mepc=0x8000_0200.
  - Redirect to 0x8000_002C.
- mret with mstatus=0x1880, mepc=0x8000_0104: mstatus write 0x1888 only (no mepc/mcause wen); redirect 0x8000_0104.
- Illegal plus pending timer interrupt with inst=0xFFFF_FFFF: mcause=2, mtval=0xFFFF_FFFF. Hold redirect_ready_i low for 5 cycles: redirect_valid_o and redirect_addr_o stay stable and hold_o stays 1.
- Assert rst_n=0 during the TRAP cycle: all wen drop asynchronously; after release no redirect is issued.

Source files
------------

// File: rtl/clint_trap_ctrl.sv
// clint_trap_ctrl: machine-mode trap controller.
// Arbitrates synchronous exceptions, enabled machine interrupts and mret.
// It writes the trap CSRs in one cycle, then issues a fetch redirect using
// a valid/ready handshake.
module clint_trap_ctrl #(
  parameter int XLEN  = 64,
  parameter int IRQ_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             jump_i,
  input  logic [XLEN-1:0]  jump_pc_i,
  input  logic [31:0]      inst_i,
  input  logic [3:0]       expt_info_i,
  input  logic [IRQ_W-1:0] irq_pend_i,
  input  logic [IRQ_W-1:0] csr_mie_i,
  input  logic [XLEN-1:0]  csr_mstatus_i,
  input  logic [XLEN-1:0]  csr_mtvec_i,
  input  logic [XLEN-1:0]  csr_mepc_i,
  output logic             mepc_wen_o,
  output logic [XLEN-1:0]  mepc_wdata_o,
  output logic             mcause_wen_o,
  output logic [XLEN-1:0]  mcause_wdata_o,
  output logic             mtval_wen_o,
  output logic [XLEN-1:0]  mtval_wdata_o,
  output logic             mstatus_wen_o,
  output logic [XLEN-1:0]  mstatus_wdata_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_addr_o,
  input  logic             redirect_ready_i,
  output logic             hold_o
);

  localparam int IDX_W = $clog2(IRQ_W);

  typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIR} state_e;

  state_e            state_q, state_d;
  logic              mepc_wen_q, mepc_wen_d;
  logic              mcause_wen_q, mcause_wen_d;
  logic              mtval_wen_q, mtval_wen_d;
  logic              mstatus_wen_q, mstatus_wen_d;
  logic [XLEN-1:0]   mepc_wdata_q, mepc_wdata_d;
  logic [XLEN-1:0]   mcause_wdata_q, mcause_wdata_d;
  logic [XLEN-1:0]   mtval_wdata_q, mtval_wdata_d;
  logic [XLEN-1:0]   mstatus_wdata_q, mstatus_wdata_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_addr_q, redirect_addr_d;

  logic              evt_illegal, evt_ecall, evt_ebreak, evt_mret;
  logic              evt_exc, evt_irq, evt_any;
  logic [IRQ_W-1:0]  irq_active;
  logic [IDX_W-1:0]  irq_idx;
  logic [XLEN-1:0]   tvec_base;

  // Interrupt selection order: 11 (external), then 3 (software), then
  // 7 (timer), then any other bit with the highest index first.
  function automatic logic [IDX_W-1:0] irq_select(input logic [IRQ_W-1:0] v);
    logic [IDX_W-1:0] sel;
    sel = '0;
    if (v[11])      sel = IDX_W'(11);
    else if (v[3])  sel = IDX_W'(3);
    else if (v[7])  sel = IDX_W'(7);
    else begin
      for (int i = 0; i < IRQ_W; i++) begin
        if (v[i]) sel = IDX_W'(i);
      end
    end
    return sel;
  endfunction

  // On trap entry: MPIE takes MIE, MIE is cleared, and MPP is set to M-mode.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // On mret: MIE is restored from MPIE, MPIE is set, and MPP stays M-mode.
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Event decode: events are considered only when decode holds a valid
  // instruction. Exceptions take priority over interrupts.
  always_comb begin
    evt_illegal = inst_valid_i & expt_info_i[3];
    evt_ecall   = inst_valid_i & expt_info_i[2];
    evt_ebreak  = inst_valid_i & expt_info_i[1];
    evt_mret    = inst_valid_i & expt_info_i[0];
    irq_active  = irq_pend_i & csr_mie_i;
    evt_exc     = evt_illegal | evt_ecall | evt_ebreak;
    evt_irq     = inst_valid_i & csr_mstatus_i[3] & (|irq_active);
    evt_any     = evt_exc | evt_irq | evt_mret;
    irq_idx     = irq_select(irq_active);
    tvec_base   = {csr_mtvec_i[XLEN-1:2], 2'b00};
  end

  // The stall request is combinational, so decode freezes in the same
  // cycle that an event is detected.
  always_comb begin
    hold_o = ((state_q == IDLE) & evt_any) | (state_q != IDLE);
  end

  // Next-state logic and next values of the CSR write / redirect registers.
  always_comb begin
    state_d          = state_q;
    mepc_wen_d       = 1'b0;
    mcause_wen_d     = 1'b0;
    mtval_wen_d      = 1'b0;
    mstatus_wen_d    = 1'b0;
    mepc_wdata_d     = mepc_wdata_q;
    mcause_wdata_d   = mcause_wdata_q;
    mtval_wdata_d    = mtval_wdata_q;
    mstatus_wdata_d  = mstatus_wdata_q;
    redirect_valid_d = redirect_valid_q;
    redirect_addr_d  = redirect_addr_q;
    unique case (state_q)
      IDLE: begin
        if (evt_exc || evt_irq) begin
          state_d         = TRAP;
          mepc_wen_d      = 1'b1;
          mcause_wen_d    = 1'b1;
          mtval_wen_d     = 1'b1;
          mstatus_wen_d   = 1'b1;
          mstatus_wdata_d = trap_mstatus(csr_mstatus_i);
          mtval_wdata_d   = evt_illegal ? XLEN'(inst_i) : '0;
          if (evt_exc) begin
            mepc_wdata_d    = pc_i;
            redirect_addr_d = tvec_base;
            if (evt_illegal)     mcause_wdata_d = XLEN'(2);
            else if (evt_ecall)  mcause_wdata_d = XLEN'(11);
            else                 mcause_wdata_d = XLEN'(3);
          end else begin
            // An interrupt arriving behind a taken branch must resume at
            // the branch target, not at the instruction being decoded.
            mepc_wdata_d   = jump_i ? jump_pc_i : pc_i;
            mcause_wdata_d = {1'b1, (XLEN-1)'(irq_idx)};
            if (csr_mtvec_i[1:0] == 2'b01)
              redirect_addr_d = tvec_base + (XLEN'(irq_idx) << 2);
            else
              redirect_addr_d = tvec_base;
          end
        end else if (evt_mret) begin
          state_d         = MRET;
          mstatus_wen_d   = 1'b1;
          mstatus_wdata_d = mret_mstatus(csr_mstatus_i);
        end
      end
      TRAP: begin
        state_d          = REDIR;
        redirect_valid_d = 1'b1;
      end
      MRET: begin
        state_d          = REDIR;
        redirect_valid_d = 1'b1;
        redirect_addr_d  = csr_mepc_i;
      end
      REDIR: begin
        if (redirect_valid_q && redirect_ready_i) begin
          state_d          = IDLE;
          redirect_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset clears every output so that an
  // abandoned sequence leaves no pending write or redirect behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      mepc_wen_q       <= 1'b0;
      mcause_wen_q     <= 1'b0;
      mtval_wen_q      <= 1'b0;
      mstatus_wen_q    <= 1'b0;
      mepc_wdata_q     <= '0;
      mcause_wdata_q   <= '0;
      mtval_wdata_q    <= '0;
      mstatus_wdata_q  <= '0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
    end else begin
      state_q          <= state_d;
      mepc_wen_q       <= mepc_wen_d;
      mcause_wen_q     <= mcause_wen_d;
      mtval_wen_q      <= mtval_wen_d;
      mstatus_wen_q    <= mstatus_wen_d;
      mepc_wdata_q     <= mepc_wdata_d;
      mcause_wdata_q   <= mcause_wdata_d;
      mtval_wdata_q    <= mtval_wdata_d;
      mstatus_wdata_q  <= mstatus_wdata_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
    end
  end

  assign mepc_wen_o       = mepc_wen_q;
  assign mepc_wdata_o     = mepc_wdata_q;
  assign mcause_wen_o     = mcause_wen_q;
  assign mcause_wdata_o   = mcause_wdata_q;
  assign mtval_wen_o      = mtval_wen_q;
  assign mtval_wdata_o    = mtval_wdata_q;
  assign mstatus_wen_o    = mstatus_wen_q;
  assign mstatus_wdata_o  = mstatus_wdata_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_addr_o  = redirect_addr_q;

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Directed testbench for clint_trap_ctrl.
module tb_clint_trap_ctrl;

  localparam int XLEN  = 64;
  localparam int IRQ_W = 16;

  logic             clk;
  logic             rst_n;
  logic             inst_valid_i;
  logic [XLEN-1:0]  pc_i;
  logic             jump_i;
  logic [XLEN-1:0]  jump_pc_i;
  logic [31:0]      inst_i;
  logic [3:0]       expt_info_i;
  logic [IRQ_W-1:0] irq_pend_i;
  logic [IRQ_W-1:0] csr_mie_i;
  logic [XLEN-1:0]  csr_mstatus_i;
  logic [XLEN-1:0]  csr_mtvec_i;
  logic [XLEN-1:0]  csr_mepc_i;
  logic             mepc_wen_o;
  logic [XLEN-1:0]  mepc_wdata_o;
  logic             mcause_wen_o;
  logic [XLEN-1:0]  mcause_wdata_o;
  logic             mtval_wen_o;
  logic [XLEN-1:0]  mtval_wdata_o;
  logic             mstatus_wen_o;
  logic [XLEN-1:0]  mstatus_wdata_o;
  logic             redirect_valid_o;
  logic [XLEN-1:0]  redirect_addr_o;
  logic             redirect_ready_i;
  logic             hold_o;

  logic [3:0]       wens;
  int               n_cmp;
  int               n_err;

  clint_trap_ctrl #(.XLEN(XLEN), .IRQ_W(IRQ_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inst_valid_i     (inst_valid_i),
    .pc_i             (pc_i),
    .jump_i           (jump_i),
    .jump_pc_i        (jump_pc_i),
    .inst_i           (inst_i),
    .expt_info_i      (expt_info_i),
    .irq_pend_i       (irq_pend_i),
    .csr_mie_i        (csr_mie_i),
    .csr_mstatus_i    (csr_mstatus_i),
    .csr_mtvec_i      (csr_mtvec_i),
    .csr_mepc_i       (csr_mepc_i),
    .mepc_wen_o       (mepc_wen_o),
    .mepc_wdata_o     (mepc_wdata_o),
    .mcause_wen_o     (mcause_wen_o),
    .mcause_wdata_o   (mcause_wdata_o),
    .mtval_wen_o      (mtval_wen_o),
    .mtval_wdata_o    (mtval_wdata_o),
    .mstatus_wen_o    (mstatus_wen_o),
    .mstatus_wdata_o  (mstatus_wdata_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_addr_o  (redirect_addr_o),
    .redirect_ready_i (redirect_ready_i),
    .hold_o           (hold_o)
  );

  assign wens = {mepc_wen_o, mcause_wen_o, mtval_wen_o, mstatus_wen_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then wait a little so that registered outputs
  // have settled before anything is sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n            = 1'b0;
    inst_valid_i     = 1'b0;
    pc_i             = '0;
    jump_i           = 1'b0;
    jump_pc_i        = '0;
    inst_i           = '0;
    expt_info_i      = '0;
    irq_pend_i       = '0;
    csr_mie_i        = '0;
    csr_mstatus_i    = '0;
    csr_mtvec_i      = '0;
    csr_mepc_i       = '0;
    redirect_ready_i = 1'b0;
    #3;
    chk("rst_wens",   XLEN'(wens), '0);
    chk("rst_hold",   XLEN'(hold_o), '0);
    chk("rst_rvalid", XLEN'(redirect_valid_o), '0);
    chk("rst_raddr",  redirect_addr_o, '0);
    chk("rst_mepc",   mepc_wdata_o, '0);
    chk("rst_mcause", mcause_wdata_o, '0);
    chk("rst_mtval",  mtval_wdata_o, '0);
    chk("rst_mstat",  mstatus_wdata_o, '0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_wens",   XLEN'(wens), '0);
      chk("idle_rvalid", XLEN'(redirect_valid_o), '0);
    end

    // ecall
    csr_mtvec_i      = 64'h8000_0000;
    csr_mstatus_i    = 64'h8;
    pc_i             = 64'h8000_0100;
    expt_info_i      = 4'b0100;
    inst_valid_i     = 1'b1;
    redirect_ready_i = 1'b1;
    #1;
    chk("ecall_hold_n", XLEN'(hold_o), 64'd1);
    step();
    inst_valid_i = 1'b0;
    expt_info_i  = '0;
    #1;
    chk("ecall_wens",   XLEN'(wens), 64'hF);
    chk("ecall_mepc",   mepc_wdata_o, 64'h8000_0100);
    chk("ecall_mcause", mcause_wdata_o, 64'd11);
    chk("ecall_mtval",  mtval_wdata_o, 64'd0);
    chk("ecall_mstat",  mstatus_wdata_o, 64'h1880);
    chk("ecall_rv_n1",  XLEN'(redirect_valid_o), 64'd0);
    chk("ecall_hold1",  XLEN'(hold_o), 64'd1);
    step();
    chk("ecall_wens2",  XLEN'(wens), 64'h0);
    chk("ecall_rvalid", XLEN'(redirect_valid_o), 64'd1);
    chk("ecall_raddr",  redirect_addr_o, 64'h8000_0000);
    step();
    chk("ecall_rv_done", XLEN'(redirect_valid_o), 64'd0);
    chk("ecall_hold_done", XLEN'(hold_o), 64'd0);
    chk("ecall_mepc_hold", mepc_wdata_o, 64'h8000_0100);

    // vectored interrupt behind a taken jump
    csr_mtvec_i   = 64'h8000_0001;
    csr_mstatus_i = 64'h8;
    irq_pend_i    = 16'h0880;
    csr_mie_i     = 16'h0880;
    jump_i        = 1'b1;
    jump_pc_i     = 64'h8000_0200;
    pc_i          = 64'h8000_0300;
    inst_valid_i  = 1'b1;
    step();
    inst_valid_i = 1'b0;
    irq_pend_i   = '0;
    jump_i       = 1'b0;
    #1;
    chk("irq_wens",   XLEN'(wens), 64'hF);
    chk("irq_mcause", mcause_wdata_o, 64'h8000_0000_0000_000B);
    chk("irq_mepc",   mepc_wdata_o, 64'h8000_0200);
    chk("irq_mtval",  mtval_wdata_o, 64'd0);
    chk("irq_mstat",  mstatus_wdata_o, 64'h1880);
    step();
    chk("irq_rvalid", XLEN'(redirect_valid_o), 64'd1);
    chk("irq_raddr",  redirect_addr_o, 64'h8000_002C);
    step();
    chk("irq_rv_done", XLEN'(redirect_valid_o), 64'd0);

    // mret
    csr_mstatus_i = 64'h1880;
    csr_mepc_i    = 64'h8000_0104;
    expt_info_i   = 4'b0001;
    inst_valid_i  = 1'b1;
    step();
    inst_valid_i = 1'b0;
    expt_info_i  = '0;
    #1;
    chk("mret_wens",  XLEN'(wens), 64'h1);
    chk("mret_mstat", mstatus_wdata_o, 64'h1888);
    step();
    chk("mret_rvalid", XLEN'(redirect_valid_o), 64'd1);
    chk("mret_raddr",  redirect_addr_o, 64'h8000_0104);
    step();
    chk("mret_rv_done", XLEN'(redirect_valid_o), 64'd0);

    // illegal instruction with a timer interrupt also pending; fetch stalls
    csr_mstatus_i    = 64'h8;
    csr_mtvec_i      = 64'h8000_0001;
    irq_pend_i       = 16'h0080;
    csr_mie_i        = 16'h0080;
    pc_i             = 64'h8000_0400;
    inst_i           = 32'hFFFF_FFFF;
    expt_info_i      = 4'b1000;
    inst_valid_i     = 1'b1;
    redirect_ready_i = 1'b0;
    step();
    inst_valid_i = 1'b0;
    expt_info_i  = '0;
    #1;
    chk("ill_wens",   XLEN'(wens), 64'hF);
    chk("ill_mcause", mcause_wdata_o, 64'd2);
    chk("ill_mtval",  mtval_wdata_o, 64'hFFFF_FFFF);
    chk("ill_mepc",   mepc_wdata_o, 64'h8000_0400);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ill_stall_rvalid", XLEN'(redirect_valid_o), 64'd1);
      chk("ill_stall_raddr",  redirect_addr_o, 64'h8000_0000);
      chk("ill_stall_hold",   XLEN'(hold_o), 64'd1);
    end
    redirect_ready_i = 1'b1;
    step();
    chk("ill_rv_done", XLEN'(redirect_valid_o), 64'd0);
    chk("ill_hold_done", XLEN'(hold_o), 64'd0);
    irq_pend_i = '0;

    // reset asserted during the TRAP cycle
    csr_mtvec_i  = 64'h8000_0000;
    pc_i         = 64'h8000_0500;
    expt_info_i  = 4'b0100;
    inst_valid_i = 1'b1;
    step();
    inst_valid_i = 1'b0;
    expt_info_i  = '0;
    #1;
    chk("rtrap_wens", XLEN'(wens), 64'hF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rtrap_wens_async", XLEN'(wens), 64'h0);
    chk("rtrap_hold_async", XLEN'(hold_o), 64'd0);
    chk("rtrap_mepc_async", mepc_wdata_o, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rtrap_rvalid", XLEN'(redirect_valid_o), 64'd0);
      chk("rtrap_wens_after", XLEN'(wens), 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
